tap_delay_line: RTL

TAP_DELAY_LINE -- requirements
Module: tap_delay_line

---
 rtl/tap_delay_pkg.sv | 19 +
 rtl/tap_delay_line_delay_stage.sv | 31 +++
 rtl/tap_delay_line.sv | 85 ++++++++
 3 files changed

// File: rtl/tap_delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tap_delay_pkg
//  Description : Shared defaults and fill-counter width helper for the tapped
//                delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
package tap_delay_pkg;

    localparam int DEFAULT_BW    = 9;
    localparam int DEFAULT_DEPTH = 8;

    // Width needed to count 0..depth inclusive.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : tap_delay_pkg
`default_nettype wire

// File: rtl/tap_delay_line_delay_stage.sv
`default_nettype none
// ============================================================================
//  Module      : delay_stage
//  Description : One BW-wide storage stage of the delay line with clock
//                enable and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_stage
    import tap_delay_pkg::*;
#(
    parameter int BW = DEFAULT_BW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          en,
    input  logic          clr,
    input  logic [BW-1:0] d,
    output logic [BW-1:0] q
);

    // Clear wins over enable; otherwise load on enable, else hold.
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : delay_stage
`default_nettype wire

// File: rtl/tap_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tap_delay_line
//  Description : DEPTH-stage shift register with per-stage taps, fill counter,
//                primed flag and a valid strobe for samples leaving a fully
//                primed line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_delay_line
    import tap_delay_pkg::*;
#(
    parameter  int BW    = DEFAULT_BW,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = fill_width(DEPTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [BW-1:0]       din,
    input  logic                din_valid,
    input  logic                flush,
    output logic [DEPTH*BW-1:0] taps,
    output logic [BW-1:0]       dout,
    output logic                dout_valid,
    output logic                primed,
    output logic [CW-1:0]       fill_count
);

    localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] C_PRE_FULL = CW'(DEPTH - 1);

    // Parameter sanity checks at elaboration time.
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "tap_delay_line: DEPTH must be >= 2");
    end
    if (BW < 1) begin : g_bad_bw
        $fatal(1, "tap_delay_line: BW must be >= 1");
    end

    logic [BW-1:0] stage_q [DEPTH];

    // Stage 0 takes din; every later stage takes its predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [BW-1:0] stage_d;
        if (k == 0) begin : g_head
            assign stage_d = din;
        end else begin : g_body
            assign stage_d = stage_q[k-1];
        end

        delay_stage #(
            .BW (BW)
        ) u_stage (
            .CLK   (CLK),
            .RESET (RESET),
            .en    (din_valid),
            .clr   (flush),
            .d     (stage_d),
            .q     (stage_q[k])
        );

        assign taps[k*BW +: BW] = stage_q[k];
    end

    assign dout = stage_q[DEPTH-1];

    // Fill counter saturates at DEPTH; primed and dout_valid are registered
    // from the post-shift fill level so they never glitch.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            fill_count <= '0;
            primed     <= 1'b0;
            dout_valid <= 1'b0;
        end else if (din_valid) begin
            if (fill_count != C_FULL) begin
                fill_count <= fill_count + 1'b1;
            end
            primed     <= (fill_count >= C_PRE_FULL);
            dout_valid <= (fill_count >= C_PRE_FULL);
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule : tap_delay_line
`default_nettype wire
